// File: rtl/rule_firing_engine_pkg.sv
// Shared definitions for the interval type-2 rule firing engine.
// Holds the FSM encoding, the rule-base geometry and the rule index decode helpers.
package rule_firing_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int N_RULES = 9;
    localparam int N_SETS  = 3;
    localparam int N_CONS  = 3;

    localparam logic [1:0] CONS_OFF  = 2'd3;
    localparam logic [3:0] LAST_RULE = 4'(N_RULES - 1);

    localparam logic [2*N_RULES-1:0] RULE_CONS_DEFAULT = 18'b10_10_01_10_01_00_01_00_00;

    // Rule k = 3*i + j: i selects the input-1 set, j the input-2 set.
    function automatic logic [1:0] rule_set_in1(input logic [3:0] k);
        logic [1:0] i;
        case (k)
            4'd0, 4'd1, 4'd2: i = 2'd0;
            4'd3, 4'd4, 4'd5: i = 2'd1;
            default:          i = 2'd2;
        endcase
        return i;
    endfunction

    function automatic logic [1:0] rule_set_in2(input logic [3:0] k);
        logic [1:0] j;
        case (k)
            4'd0, 4'd3, 4'd6: j = 2'd0;
            4'd1, 4'd4, 4'd7: j = 2'd1;
            default:          j = 2'd2;
        endcase
        return j;
    endfunction

    function automatic logic [1:0] rule_cons(input logic [2*N_RULES-1:0] tab,
                                             input logic [3:0]           k);
        logic [1:0] c;
        c = CONS_OFF;
        for (int r = 0; r < N_RULES; r++) begin
            if (k == 4'(r)) c = tab[2*r +: 2];
        end
        return c;
    endfunction

endpackage

// File: rtl/rule_firing_engine_minmax_unit.sv
// Combinational firing step: min of two antecedent grades, then max against
// the running aggregate for the selected consequent set.
module minmax_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] grade_a,
    input  logic [W-1:0] grade_b,
    input  logic [W-1:0] acc,
    output logic [W-1:0] fire,
    output logic [W-1:0] acc_max
);

    always_comb begin
        fire    = (grade_a < grade_b) ? grade_a : grade_b;
        acc_max = (fire > acc) ? fire : acc;
    end

endmodule

// File: rtl/rule_firing_engine.sv
// Serial 9-rule interval type-2 inference: one rule per enabled cycle, max-aggregated
// per consequent set, results published with a one-cycle Valid pulse.
module rule_firing_engine
    import rule_firing_engine_pkg::*;
#(
    parameter int                   W         = 8,
    parameter logic [2*N_RULES-1:0] RULE_CONS = RULE_CONS_DEFAULT
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         EN_SCLK,
    input  logic         Start,
    input  logic [W-1:0] FOU_01_UP,
    input  logic [W-1:0] FOU_02_UP,
    input  logic [W-1:0] FOU_03_UP,
    input  logic [W-1:0] FOU_01_LOW,
    input  logic [W-1:0] FOU_02_LOW,
    input  logic [W-1:0] FOU_03_LOW,
    input  logic [W-1:0] FOU_04_UP,
    input  logic [W-1:0] FOU_05_UP,
    input  logic [W-1:0] FOU_06_UP,
    input  logic [W-1:0] FOU_04_LOW,
    input  logic [W-1:0] FOU_05_LOW,
    input  logic [W-1:0] FOU_06_LOW,
    input  logic [5:0]   Ativo_UP,
    output logic [W-1:0] OUT_1_UP,
    output logic [W-1:0] OUT_2_UP,
    output logic [W-1:0] OUT_3_UP,
    output logic [W-1:0] OUT_1_LOW,
    output logic [W-1:0] OUT_2_LOW,
    output logic [W-1:0] OUT_3_LOW,
    output logic         Busy,
    output logic         Valid,
    output state_e       dbg_state
);

    localparam int N_GRADES = 2 * N_SETS;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   act_q, act_d;
    logic         valid_q, valid_d;
    logic         busy;
    logic [W-1:0] g_up_q  [N_GRADES];
    logic [W-1:0] g_up_d  [N_GRADES];
    logic [W-1:0] g_low_q [N_GRADES];
    logic [W-1:0] g_low_d [N_GRADES];
    logic [W-1:0] acc_up_q  [N_CONS];
    logic [W-1:0] acc_up_d  [N_CONS];
    logic [W-1:0] acc_low_q [N_CONS];
    logic [W-1:0] acc_low_d [N_CONS];
    logic [W-1:0] out_up_q  [N_CONS];
    logic [W-1:0] out_up_d  [N_CONS];
    logic [W-1:0] out_low_q [N_CONS];
    logic [W-1:0] out_low_d [N_CONS];

    logic [1:0]   rule_i, rule_j, cons, acc_sel;
    logic [2:0]   idx_a, idx_b;
    logic         rule_act;
    logic [W-1:0] fire_up, fire_low, max_up, max_low;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else if (EN_SCLK) begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EVAL;
            ST_EVAL: if (cnt_q == LAST_RULE) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = (state_q != ST_IDLE);
        valid_d = (state_q == ST_DONE);
    end

    // ---------------- rule decode for the current counter value ----------------
    always_comb begin
        rule_i   = rule_set_in1(cnt_q);
        rule_j   = rule_set_in2(cnt_q);
        cons     = rule_cons(RULE_CONS, cnt_q);
        acc_sel  = (cons == CONS_OFF) ? 2'd0 : cons;
        idx_a    = {1'b0, rule_i};
        idx_b    = 3'd3 + {1'b0, rule_j};
        rule_act = act_q[3'd5 - {1'b0, rule_i}] && act_q[3'd2 - {1'b0, rule_j}]
                   && (cons != CONS_OFF);
    end

    minmax_unit #(.W(W)) u_minmax_up (
        .grade_a (g_up_q[idx_a]),
        .grade_b (g_up_q[idx_b]),
        .acc     (acc_up_q[acc_sel]),
        .fire    (fire_up),
        .acc_max (max_up)
    );

    minmax_unit #(.W(W)) u_minmax_low (
        .grade_a (g_low_q[idx_a]),
        .grade_b (g_low_q[idx_b]),
        .acc     (acc_low_q[acc_sel]),
        .fire    (fire_low),
        .acc_max (max_low)
    );

    // ---------------- datapath next-state ----------------
    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        g_up_d    = g_up_q;
        g_low_d   = g_low_q;
        acc_up_d  = acc_up_q;
        acc_low_d = acc_low_q;
        out_up_d  = out_up_q;
        out_low_d = out_low_q;
        case (state_q)
            ST_IDLE: begin
                // Inputs are captured on the accepting edge so Start alone defines the sample.
                if (Start) begin
                    g_up_d  = '{FOU_01_UP, FOU_02_UP, FOU_03_UP,
                                FOU_04_UP, FOU_05_UP, FOU_06_UP};
                    g_low_d = '{FOU_01_LOW, FOU_02_LOW, FOU_03_LOW,
                                FOU_04_LOW, FOU_05_LOW, FOU_06_LOW};
                    act_d   = Ativo_UP;
                end
            end
            ST_LOAD: begin
                cnt_d = '0;
                for (int c = 0; c < N_CONS; c++) begin
                    acc_up_d[c]  = '0;
                    acc_low_d[c] = '0;
                end
            end
            ST_EVAL: begin
                if (rule_act) begin
                    acc_up_d[acc_sel]  = max_up;
                    acc_low_d[acc_sel] = max_low;
                end
                cnt_d = cnt_q + 4'd1;
            end
            ST_DONE: begin
                out_up_d  = acc_up_q;
                out_low_d = acc_low_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            cnt_q   <= '0;
            act_q   <= '0;
            valid_q <= 1'b0;
            for (int s = 0; s < N_GRADES; s++) begin
                g_up_q[s]  <= '0;
                g_low_q[s] <= '0;
            end
            for (int c = 0; c < N_CONS; c++) begin
                acc_up_q[c]  <= '0;
                acc_low_q[c] <= '0;
                out_up_q[c]  <= '0;
                out_low_q[c] <= '0;
            end
        end else if (EN_SCLK) begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            valid_q   <= valid_d;
            g_up_q    <= g_up_d;
            g_low_q   <= g_low_d;
            acc_up_q  <= acc_up_d;
            acc_low_q <= acc_low_d;
            out_up_q  <= out_up_d;
            out_low_q <= out_low_d;
        end
    end

    assign OUT_1_UP  = out_up_q[0];
    assign OUT_2_UP  = out_up_q[1];
    assign OUT_3_UP  = out_up_q[2];
    assign OUT_1_LOW = out_low_q[0];
    assign OUT_2_LOW = out_low_q[1];
    assign OUT_3_LOW = out_low_q[2];
    assign Busy      = busy;
    assign Valid     = valid_q;
    assign dbg_state = state_q;

    // fire_up/fire_low are the per-rule strengths; only the aggregate is stored.
    logic unused_fire;
    assign unused_fire = ^{fire_up, fire_low};

endmodule

// File: tb/tb_rule_firing_engine.sv
// Randomized bench for rule_firing_engine: two instances (default rule base and one with
// rule 0 disabled) checked against a loop-level min/max model via an expected queue.
module tb_rule_firing_engine;
    import rule_firing_engine_pkg::*;

    localparam int W = 8;
    localparam logic [17:0] CONS_A = 18'b10_10_01_10_01_00_01_00_00;
    localparam logic [17:0] CONS_B = 18'b10_10_01_10_01_00_01_00_11;

    logic         clk = 1'b0;
    logic         RESET = 1'b0;
    logic         EN_SCLK = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] up1 [3];
    logic [W-1:0] low1 [3];
    logic [W-1:0] up2 [3];
    logic [W-1:0] low2 [3];
    logic [5:0]   act;

    logic [W-1:0] oa_up [3];
    logic [W-1:0] oa_low [3];
    logic [W-1:0] ob_up [3];
    logic [W-1:0] ob_low [3];
    logic         va, vb, ba, bb;
    state_e       sa, sb;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rule_firing_engine #(.W(W), .RULE_CONS(CONS_A)) u_dut_a (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .Start(Start),
        .FOU_01_UP(up1[0]), .FOU_02_UP(up1[1]), .FOU_03_UP(up1[2]),
        .FOU_01_LOW(low1[0]), .FOU_02_LOW(low1[1]), .FOU_03_LOW(low1[2]),
        .FOU_04_UP(up2[0]), .FOU_05_UP(up2[1]), .FOU_06_UP(up2[2]),
        .FOU_04_LOW(low2[0]), .FOU_05_LOW(low2[1]), .FOU_06_LOW(low2[2]),
        .Ativo_UP(act),
        .OUT_1_UP(oa_up[0]), .OUT_2_UP(oa_up[1]), .OUT_3_UP(oa_up[2]),
        .OUT_1_LOW(oa_low[0]), .OUT_2_LOW(oa_low[1]), .OUT_3_LOW(oa_low[2]),
        .Busy(ba), .Valid(va), .dbg_state(sa)
    );

    rule_firing_engine #(.W(W), .RULE_CONS(CONS_B)) u_dut_b (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .Start(Start),
        .FOU_01_UP(up1[0]), .FOU_02_UP(up1[1]), .FOU_03_UP(up1[2]),
        .FOU_01_LOW(low1[0]), .FOU_02_LOW(low1[1]), .FOU_03_LOW(low1[2]),
        .FOU_04_UP(up2[0]), .FOU_05_UP(up2[1]), .FOU_06_UP(up2[2]),
        .FOU_04_LOW(low2[0]), .FOU_05_LOW(low2[1]), .FOU_06_LOW(low2[2]),
        .Ativo_UP(act),
        .OUT_1_UP(ob_up[0]), .OUT_2_UP(ob_up[1]), .OUT_3_UP(ob_up[2]),
        .OUT_1_LOW(ob_low[0]), .OUT_2_LOW(ob_low[1]), .OUT_3_LOW(ob_low[2]),
        .Busy(bb), .Valid(vb), .dbg_state(sb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every (i,j) pair of active sets fires min() into its consequent, aggregated by max().
    task automatic model_push(input logic [17:0] tab);
        int eu [3];
        int el [3];
        for (int c = 0; c < 3; c++) begin eu[c] = 0; el[c] = 0; end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int k, c, fu, fl;
                k = 3 * i + j;
                c = int'((tab >> (2 * k)) & 18'd3);
                if (act[5 - i] && act[2 - j] && c != 3) begin
                    fu = (up1[i] < up2[j]) ? int'(up1[i]) : int'(up2[j]);
                    fl = (low1[i] < low2[j]) ? int'(low1[i]) : int'(low2[j]);
                    if (fu > eu[c]) eu[c] = fu;
                    if (fl > el[c]) el[c] = fl;
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(W'(eu[c]));
            exp_q.push_back(W'(el[c]));
        end
    endtask

    task automatic set_grades(input int u1a, l1a, u1b, l1b, u2a, l2a, input logic [5:0] a);
        for (int s = 0; s < 3; s++) begin
            up1[s] = '0; low1[s] = '0; up2[s] = '0; low2[s] = '0;
        end
        up1[0] = W'(u1a); low1[0] = W'(l1a);
        up1[1] = W'(u1b); low1[1] = W'(l1b);
        up2[0] = W'(u2a); low2[0] = W'(l2a);
        act = a;
    endtask

    task automatic randomize_grades();
        for (int s = 0; s < 3; s++) begin
            up1[s]  = W'($urandom_range(0, 255));
            low1[s] = W'($urandom_range(0, 255));
            up2[s]  = W'($urandom_range(0, 255));
            low2[s] = W'($urandom_range(0, 255));
        end
        act = 6'($urandom_range(0, 63));
    endtask

    task automatic compare_outputs(input string name);
        logic [W-1:0] e;
        for (int c = 0; c < 3; c++) begin
            e = exp_q.pop_front(); check($sformatf("%s a_up%0d", name, c + 1), oa_up[c], e);
            e = exp_q.pop_front(); check($sformatf("%s a_low%0d", name, c + 1), oa_low[c], e);
        end
        for (int c = 0; c < 3; c++) begin
            e = exp_q.pop_front(); check($sformatf("%s b_up%0d", name, c + 1), ob_up[c], e);
            e = exp_q.pop_front(); check($sformatf("%s b_low%0d", name, c + 1), ob_low[c], e);
        end
    endtask

    // Starts one run from IDLE; optionally stalls EN_SCLK and pokes Start while busy / at DONE.
    task automatic run_case(input string name, input int stall_at, input int stall_len,
                            input bit poke);
        int lat, nva, nvb, extra;
        bit seen;
        logic [W-1:0] held;
        model_push(CONS_A);
        model_push(CONS_B);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        lat = 0; seen = 1'b0; nva = 0; nvb = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (stall_len > 0 && c == stall_at) EN_SCLK = 1'b0;
            if (stall_len > 0 && c == stall_at + stall_len) EN_SCLK = 1'b1;
            if (poke && c == 5) Start = 1'b1;
            if (poke && c == 6) Start = 1'b0;
            if (poke && c == 11) Start = 1'b1;
            tick();
            if (c == 4) check({name, " busy_mid"}, {30'd0, ba, bb}, 32'd3);
            if (va) nva++;
            if (vb) nvb++;
            if (va && !seen) begin seen = 1'b1; lat = c; end
        end
        Start = 1'b0;
        EN_SCLK = 1'b1;
        check({name, " latency"}, lat, 11 + stall_len);
        check({name, " valid_b_same_cycle"}, nvb, 1);
        check({name, " busy_after"}, {30'd0, ba, bb}, 32'd0);
        compare_outputs(name);
        held = oa_up[0];
        tick();
        check({name, " valid_pulse"}, {30'd0, va, vb}, 32'd0);
        extra = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (va || vb || ba || bb) extra++;
        end
        check({name, " no_extra_run"}, extra, 0);
        check({name, " out_held"}, oa_up[0], held);
    endtask

    task automatic run_abort();
        int stray;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        check("abort busy_before", {30'd0, ba, bb}, 32'd3);
        RESET = 1'b0;
        #1;
        check("abort outs_a", {oa_up[0], oa_up[1], oa_up[2]} | {oa_low[0], oa_low[1], oa_low[2]}, 0);
        check("abort outs_b", {ob_up[0], ob_up[1], ob_up[2]} | {ob_low[0], ob_low[1], ob_low[2]}, 0);
        check("abort flags", {28'd0, va, vb, ba, bb}, 0);
        check("abort state", {sa, sb}, {ST_IDLE, ST_IDLE});
        #2;
        RESET = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (va || vb) stray++;
        end
        check("abort no_valid", stray, 0);
    endtask

    initial begin
        set_grades(0, 0, 0, 0, 0, 0, 6'b0);
        RESET = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outs_a", {oa_up[0], oa_up[1], oa_up[2]} | {oa_low[0], oa_low[1], oa_low[2]}, 0);
        check("reset outs_b", {ob_up[0], ob_up[1], ob_up[2]} | {ob_low[0], ob_low[1], ob_low[2]}, 0);
        check("reset flags", {28'd0, va, vb, ba, bb}, 0);
        check("reset state", {sa, sb}, {ST_IDLE, ST_IDLE});
        RESET = 1'b1;
        tick();

        set_grades(200, 150, 80, 40, 100, 60, 6'b110100);
        run_case("basic", 0, 0, 1'b0);
        set_grades(200, 150, 80, 40, 100, 60, 6'b010100);
        run_case("masked", 0, 0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            up1[s] = 8'd255; low1[s] = 8'd128; up2[s] = 8'd255; low2[s] = 8'd128;
        end
        act = 6'b111111;
        run_case("all_active", 0, 0, 1'b0);
        set_grades(200, 150, 80, 40, 100, 60, 6'b110100);
        run_case("start_busy", 0, 0, 1'b1);
        randomize_grades();
        run_case("stall", 4, 5, 1'b0);

        run_abort();
        set_grades(90, 30, 120, 110, 70, 65, 6'b111100);
        run_case("post_abort", 0, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            randomize_grades();
            if ($urandom_range(0, 3) == 0)
                run_case($sformatf("rand%0d", r), int'($urandom_range(3, 7)),
                         int'($urandom_range(1, 5)), 1'b0);
            else
                run_case($sformatf("rand%0d", r), 0, 0, ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
